// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage valid/ready register chain with flush, bubble collapsing and drop counting.
// Optional macro PIPE_STAGE_SKID_EN adds a one-entry skid register ahead of stage 0 (registered in_ready).
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [WIDTH-1:0]           i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [WIDTH-1:0]           o_out_data,
    output logic [$clog2(DEPTH+2)-1:0] o_occupancy,
    output logic [15:0]                o_drop_cnt
);
    localparam int CW = $clog2(DEPTH+2);

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH:0]   w_ok;
    logic             w_accept;
    logic             w_pop;
    logic             w_load0;
    logic [WIDTH-1:0] w_src0;
    logic [CW-1:0]    w_held;
    logic [16:0]      w_drop_sum;
    logic [CW-1:0]    r_occ;
    logic [15:0]      r_drop;

    // Walk from the output back so each stage sees whether its downstream slot frees this cycle.
    always_comb begin
        w_adv        = '0;
        w_ok         = '0;
        w_ok[DEPTH]  = i_out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_adv[i] = w_v[i] & w_ok[i+1];
            w_ok[i]  = ~w_v[i] | w_adv[i];
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic             r_skid_v;
    logic [WIDTH-1:0] r_skid_d;

    assign o_in_ready = ~r_skid_v;
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_load0    = w_ok[0] & (r_skid_v | w_accept);
    assign w_src0     = r_skid_v ? r_skid_d : i_in_data;

    // An accepted word parks here only when stage 0 cannot take it this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_v <= 1'b0;
            r_skid_d <= '0;
        end else begin
            if (i_flush)
                r_skid_v <= 1'b0;
            else if (r_skid_v)
                r_skid_v <= ~w_ok[0];
            else
                r_skid_v <= w_accept & ~w_ok[0];
            if (w_accept & ~w_ok[0])
                r_skid_d <= i_in_data;
        end
    end
`else
    assign o_in_ready = w_ok[0];
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_load0    = w_accept;
    assign w_src0     = i_in_data;
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             w_load;
            logic [WIDTH-1:0] w_src;
            logic             r_valid;
            logic [WIDTH-1:0] r_data;

            if (gi == 0) begin : g_head
                assign w_load = w_load0;
                assign w_src  = w_src0;
            end else begin : g_body
                assign w_load = w_adv[gi-1];
                assign w_src  = w_d[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    if (i_flush)
                        r_valid <= 1'b0;
                    else
                        r_valid <= w_load | (r_valid & ~w_adv[gi]);
                    if (w_load)
                        r_data <= w_src;
                end
            end

            assign w_v[gi] = r_valid;
            assign w_d[gi] = r_data;
        end
    endgenerate

    // Words still held after this edge's pop and accept; on flush these are the ones discarded.
    assign w_pop      = w_adv[DEPTH-1];
    assign w_held     = r_occ + CW'(w_accept) - CW'(w_pop);
    assign w_drop_sum = {1'b0, r_drop} + 17'(w_held);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= '0;
            r_drop <= '0;
        end else if (i_flush) begin
            r_occ  <= '0;
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end else begin
            r_occ  <= w_held;
        end
    end

    assign o_out_valid = w_v[DEPTH-1];
    assign o_out_data  = w_d[DEPTH-1];
    assign o_occupancy = r_occ;
    assign o_drop_cnt  = r_drop;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus random traffic checked against a word-position queue model.
module tb_pipe_stage_chain;
    localparam int W   = 32;
    localparam int D   = 3;
    localparam int TCW = $clog2(D + 2);
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID    = 1'b1;
    localparam int CAP     = D + 1;
    localparam int FL_DROP = 4;
`else
    localparam bit SKID    = 1'b0;
    localparam int CAP     = D;
    localparam int FL_DROP = 3;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_ready, out_valid;
    logic [W-1:0]   out_data;
    logic [TCW-1:0] occ;
    logic [15:0]    drop;

    logic           flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [7:0]     in_data1 = '0;
    logic           in_ready1, out_valid1;
    logic [7:0]     out_data1;
    logic [1:0]     occ1;
    logic [15:0]    drop1;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_occupancy(occ), .o_drop_cnt(drop)
    );

    pipe_stage_chain #(.WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_flush(flush1), .i_in_valid(in_valid1), .o_in_ready(in_ready1),
        .i_in_data(in_data1), .o_out_valid(out_valid1), .i_out_ready(out_ready1), .o_out_data(out_data1),
        .o_occupancy(occ1), .o_drop_cnt(drop1)
    );

    always #5 clk = ~clk;

    // Model: queue of held words, oldest first, each with its stage index (-1 = skid).
    // A word advances one slot per edge unless blocked by the slot claimed by the word ahead of it.
    int           pos_q[$];
    logic [W-1:0] dat_q[$];
    int           m_drop;

    function automatic bit m_valid();
        return (pos_q.size() > 0) && (pos_q[0] == D - 1);
    endfunction

    function automatic logic [W-1:0] m_head();
        return (dat_q.size() > 0) ? dat_q[0] : '0;
    endfunction

    function automatic int move_cap(input bit ordy);
        int cap = D - 1;
        int np;
        for (int i = 0; i < pos_q.size(); i++) begin
            if (i == 0 && pos_q[0] == D - 1 && ordy) continue;
            np  = (pos_q[i] + 1 < cap) ? pos_q[i] + 1 : cap;
            cap = np - 1;
        end
        return cap;
    endfunction

    function automatic bit pred_ready(input bit ordy);
        if (SKID) return !(pos_q.size() > 0 && pos_q[pos_q.size()-1] == -1);
        return move_cap(ordy) >= 0;
    endfunction

    task automatic model_edge(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl, output bit acc);
        int cap;
        int np;
        acc = v && pred_ready(ordy);
        if (m_valid() && ordy) begin
            void'(pos_q.pop_front());
            void'(dat_q.pop_front());
        end
        cap = D - 1;
        for (int i = 0; i < pos_q.size(); i++) begin
            np       = (pos_q[i] + 1 < cap) ? pos_q[i] + 1 : cap;
            pos_q[i] = np;
            cap      = np - 1;
        end
        if (acc) begin
            pos_q.push_back((cap >= 0) ? 0 : cap);
            dat_q.push_back(d);
        end
        if (fl) begin
            m_drop += pos_q.size();
            if (m_drop > 65535) m_drop = 65535;
            pos_q.delete();
            dat_q.delete();
        end
    endtask

    task automatic set_in(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
        in_valid = v; in_data = d; out_ready = ordy; flush = fl;
        #1;
    endtask

    task automatic clock_edge(output bit acc);
        @(posedge clk);
        model_edge(in_valid, in_data, out_ready, flush, acc);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, 1'b0, 1'b0);
        in_valid1 = 1'b0; out_ready1 = 1'b0; flush1 = 1'b0; in_data1 = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        pos_q.delete(); dat_q.delete(); m_drop = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_tests++; if (occ !== '0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occ); end
        n_tests++; if (drop !== '0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_d1_out_valid: got %0b want 0", out_valid1); end
        $display("[TB] reset: state checked");
        do_reset();
    endtask

    task automatic test_stream();
        bit           acc;
        int           first_v = -1;
        int           peak = 0;
        bit           ok = 1'b1;
        logic [W-1:0] got[$];
        do_reset();
        for (int c = 0; c < 14; c++) begin
            set_in(c < 8, W'(32'h11 + c), 1'b1, 1'b0);
            n_tests++;
            if (out_valid !== m_valid() || (m_valid() && out_data !== m_head())) begin
                n_fail++; $display("FAIL stream_out c=%0d: got v=%0b d=%h want v=%0b d=%h", c, out_valid, out_data, m_valid(), m_head());
            end
            n_tests++; if (in_ready !== pred_ready(1'b1)) begin n_fail++; $display("FAIL stream_in_ready c=%0d: got %0b want %0b", c, in_ready, pred_ready(1'b1)); end
            n_tests++; if (occ !== TCW'(pos_q.size())) begin n_fail++; $display("FAIL stream_occ c=%0d: got %0d want %0d", c, occ, pos_q.size()); end
            if (out_valid === 1'b1) begin
                got.push_back(out_data);
                if (first_v < 0) first_v = c;
            end
            if (int'(occ) > peak) peak = int'(occ);
            $display("[TB] stream c=%0d in=%h out_v=%0b out=%h occ=%0d", c, in_data, out_valid, out_data, occ);
            clock_edge(acc);
        end
        n_tests++; if (first_v != D) begin n_fail++; $display("FAIL stream_latency: got cycle %0d want %0d", first_v, D); end
        n_tests++; if (peak != D) begin n_fail++; $display("FAIL stream_peak_occ: got %0d want %0d", peak, D); end
        if (got.size() != 8) ok = 1'b0;
        for (int k = 0; k < got.size() && k < 8; k++) if (got[k] !== W'(32'h11 + k)) ok = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stream_order: got %0d words want 8 in order 11..18", got.size()); end
    endtask

    task automatic test_stall_fill();
        bit           acc;
        int           k = 0;
        bit           ok = 1'b1;
        logic [W-1:0] got[$];
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_in(1'b1, W'(32'hA0 + k), 1'b0, 1'b0);
            n_tests++; if (in_ready !== pred_ready(1'b0)) begin n_fail++; $display("FAIL fill_in_ready c=%0d: got %0b want %0b", c, in_ready, pred_ready(1'b0)); end
            if (in_ready === 1'b1) k++;
            $display("[TB] fill c=%0d in=%h ready=%0b occ=%0d", c, in_data, in_ready, occ);
            clock_edge(acc);
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_tests++; if (k != CAP) begin n_fail++; $display("FAIL fill_accepted: got %0d want %0d", k, CAP); end
        n_tests++; if (occ !== TCW'(CAP)) begin n_fail++; $display("FAIL fill_occ: got %0d want %0d", occ, CAP); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %0b want 0", in_ready); end
        for (int c = 0; c < 8; c++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            n_tests++;
            if (out_valid !== m_valid() || (m_valid() && out_data !== m_head())) begin
                n_fail++; $display("FAIL drain_out c=%0d: got v=%0b d=%h want v=%0b d=%h", c, out_valid, out_data, m_valid(), m_head());
            end
            if (out_valid === 1'b1) got.push_back(out_data);
            $display("[TB] drain c=%0d out_v=%0b out=%h", c, out_valid, out_data);
            clock_edge(acc);
        end
        if (got.size() != CAP) ok = 1'b0;
        for (int j = 0; j < got.size() && j < CAP; j++) if (got[j] !== W'(32'hA0 + j)) ok = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL drain_order: got %0d words want %0d from A0 in order", got.size(), CAP); end
    endtask

    task automatic test_bubble();
        bit acc;
        do_reset();
        set_in(1'b1, W'(32'h1), 1'b0, 1'b0); clock_edge(acc);
        set_in(1'b0, '0, 1'b0, 1'b0);        clock_edge(acc);
        set_in(1'b0, '0, 1'b0, 1'b0);        clock_edge(acc);
        set_in(1'b1, W'(32'h2), 1'b0, 1'b0); clock_edge(acc);
        set_in(1'b0, '0, 1'b0, 1'b0);        clock_edge(acc);
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || out_data !== W'(32'h1)) begin n_fail++; $display("FAIL bubble_head: got v=%0b d=%h want v=1 d=1", out_valid, out_data); end
        n_tests++; if (occ !== TCW'(2)) begin n_fail++; $display("FAIL bubble_occ: got %0d want 2", occ); end
        $display("[TB] bubble stalled out=%h occ=%0d", out_data, occ);
        set_in(1'b0, '0, 1'b1, 1'b0); clock_edge(acc);
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || out_data !== W'(32'h2)) begin n_fail++; $display("FAIL bubble_collapsed: got v=%0b d=%h want v=1 d=2", out_valid, out_data); end
        n_tests++; if (occ !== TCW'(1)) begin n_fail++; $display("FAIL bubble_occ_after: got %0d want 1", occ); end
        $display("[TB] bubble released out=%h occ=%0d", out_data, occ);
    endtask

    task automatic test_flush();
        bit acc;
        bit seen_ff = 1'b0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, W'(32'h31 + c), 1'b0, 1'b0);
            clock_edge(acc);
        end
        set_in(1'b1, W'(32'hFF), 1'b0, 1'b1);
        clock_edge(acc);
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
        n_tests++; if (occ !== '0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occ); end
        n_tests++; if (drop !== 16'(FL_DROP)) begin n_fail++; $display("FAIL flush_drop_cnt: got %0d want %0d", drop, FL_DROP); end
        $display("[TB] flush drop=%0d occ=%0d", drop, occ);
        for (int c = 0; c < 6; c++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            if (out_valid === 1'b1) seen_ff = 1'b1;
            clock_edge(acc);
        end
        n_tests++; if (seen_ff) begin n_fail++; $display("FAIL flush_leak: got a word after flush want none"); end
    endtask

    task automatic test_async_reset();
        bit acc;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_in(1'b1, W'(32'h60 + c), 1'b1, c == 2);
            clock_edge(acc);
        end
        set_in(1'b1, W'(32'h66), 1'b1, 1'b0);
        n_tests++; if (occ !== TCW'(pos_q.size()) || drop !== 16'(m_drop)) begin n_fail++; $display("FAIL areset_pre: got occ=%0d drop=%0d want occ=%0d drop=%0d", occ, drop, pos_q.size(), m_drop); end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL areset_out: got v=%0b d=%h want v=0 d=0", out_valid, out_data); end
        n_tests++; if (occ !== '0 || drop !== '0) begin n_fail++; $display("FAIL areset_counters: got occ=%0d drop=%0d want 0 0", occ, drop); end
        $display("[TB] async reset out_v=%0b occ=%0d drop=%0d", out_valid, occ, drop);
        #2;
        set_in(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        pos_q.delete(); dat_q.delete(); m_drop = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            set_in(c == 0, W'(32'h55), 1'b1, 1'b0);
            n_tests++;
            if (out_valid !== (c == D) || (c == D && out_data !== W'(32'h55))) begin
                n_fail++; $display("FAIL areset_first_word c=%0d: got v=%0b d=%h want v=%0b d=55", c, out_valid, out_data, c == D);
            end
            clock_edge(acc);
        end
    endtask

    task automatic test_depth1();
        bit ev[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        bit [7:0] ed[4] = '{8'h00, 8'h40, 8'h00, 8'h42};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            in_valid1 = 1'b1; in_data1 = 8'(8'h30 + c); out_ready1 = 1'b1; flush1 = 1'b0;
            #1;
            n_tests++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL d1_in_ready c=%0d: got %0b want 1", c, in_ready1); end
            n_tests++;
            if (out_valid1 !== (c > 0) || (c > 0 && out_data1 !== 8'(8'h30 + c - 1))) begin
                n_fail++; $display("FAIL d1_pass c=%0d: got v=%0b d=%h want v=%0b d=%h", c, out_valid1, out_data1, c > 0, 8'(8'h30 + c - 1));
            end
            $display("[TB] d1 c=%0d in=%h out_v=%0b out=%h", c, in_data1, out_valid1, out_data1);
            @(posedge clk);
            #1;
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            in_valid1 = 1'b1; in_data1 = 8'(8'h40 + c); out_ready1 = 1'b1; flush1 = (c == 1);
            #1;
            n_tests++;
            if (out_valid1 !== ev[c] || (ev[c] && out_data1 !== ed[c])) begin
                n_fail++; $display("FAIL d1_flush_out c=%0d: got v=%0b d=%h want v=%0b d=%h", c, out_valid1, out_data1, ev[c], ed[c]);
            end
            $display("[TB] d1 flush c=%0d in=%h fl=%0b out_v=%0b out=%h", c, in_data1, flush1, out_valid1, out_data1);
            @(posedge clk);
            #1;
        end
        n_tests++; if (drop1 !== 16'd1) begin n_fail++; $display("FAIL d1_drop_cnt: got %0d want 1", drop1); end
        in_valid1 = 1'b0; flush1 = 1'b0;
    endtask

    task automatic test_random();
        bit acc;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 99) < 70, W'($urandom), $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4);
            n_tests++;
            if (out_valid !== m_valid() || (m_valid() && out_data !== m_head())) begin
                n_fail++; $display("FAIL rand_out c=%0d: got v=%0b d=%h want v=%0b d=%h", c, out_valid, out_data, m_valid(), m_head());
            end
            n_tests++; if (in_ready !== pred_ready(out_ready)) begin n_fail++; $display("FAIL rand_in_ready c=%0d: got %0b want %0b", c, in_ready, pred_ready(out_ready)); end
            n_tests++; if (occ !== TCW'(pos_q.size())) begin n_fail++; $display("FAIL rand_occ c=%0d: got %0d want %0d", c, occ, pos_q.size()); end
            n_tests++; if (drop !== 16'(m_drop)) begin n_fail++; $display("FAIL rand_drop c=%0d: got %0d want %0d", c, drop, m_drop); end
            $display("[TB] rand c=%0d iv=%0b in=%h or=%0b fl=%0b ov=%0b out=%h occ=%0d drop=%0d",
                     c, in_valid, in_data, out_ready, flush, out_valid, out_data, occ, drop);
            clock_edge(acc);
        end
    endtask

    initial begin
        pos_q.delete(); dat_q.delete(); m_drop = 0;
        test_reset();
        test_stream();
        test_stall_fill();
        test_bubble();
        test_flush();
        test_async_reset();
        test_depth1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
